// File: rtl/program_sequencer_if.sv
// Issue-side bundle between the program sequencer, its synchronous program
// ROM and the processor's run/done/DIN instruction port.
interface program_sequencer_if #(
  parameter int AW = 5
);
  logic [AW-1:0] prog_addr;  // ROM address, registered in the sequencer
  logic [8:0]    prog_data;  // ROM data, one cycle after prog_addr is sampled
  logic [8:0]    din;        // instruction / immediate word to the processor
  logic          run;        // processor run
  logic          done;       // processor done (final step of an instruction)

  modport master (
    output prog_addr,
    output din,
    output run,
    input  prog_data,
    input  done
  );

  modport slave (
    input  prog_addr,
    input  din,
    input  run,
    output prog_data,
    output done
  );
endinterface

// File: rtl/program_sequencer.sv
// Program sequencer: walks a PC through a synchronous program ROM and issues
// each word to the processor over run/done/DIN. MVI also presents its
// immediate (the following ROM word). Stops on HALT, at the program end, on
// an MVI whose immediate would lie past the program end, or on a watchdog
// timeout while waiting for done.
module program_sequencer #(
  parameter int AW        = 5,
  parameter int PROG_LAST = 2**AW - 1,
  parameter int TIMEOUT   = 7
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  program_sequencer_if.master bus,
  output logic                busy,
  output logic                halted,
  output logic                err,
  output logic [AW-1:0]       pc,
  output logic [15:0]         retired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_MVI  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] pc_reg, pc_next;
  logic [AW-1:0] prog_addr_reg, prog_addr_next;
  logic [15:0]   retired_reg, retired_next;
  logic          err_reg, err_next;
  logic [2:0]    op_q_reg, op_q_next;
  logic [CW-1:0] wd_reg, wd_next;

  logic          run_w;
  logic [8:0]    din_w;
  logic [2:0]    opcode;
  logic [AW:0]   pc_step;
  logic          pc_is_last;

  assign opcode     = bus.prog_data[8:6];
  assign pc_is_last = (pc_reg == AW'(PROG_LAST));

  // Next PC in AW+1 bits so stepping past the last address is detectable
  assign pc_step = {1'b0, pc_reg} +
                   ((op_q_reg == OP_MVI) ? (AW+1)'(2) : (AW+1)'(1));

  // State and datapath registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      pc_reg        <= '0;
      prog_addr_reg <= '0;
      retired_reg   <= '0;
      err_reg       <= 1'b0;
      op_q_reg      <= '0;
      wd_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      prog_addr_reg <= prog_addr_next;
      retired_reg   <= retired_next;
      err_reg       <= err_next;
      op_q_reg      <= op_q_next;
      wd_reg        <= wd_next;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    prog_addr_next = prog_addr_reg;
    retired_next   = retired_reg;
    err_next       = err_reg;
    op_q_next      = op_q_reg;
    wd_next        = wd_reg;
    run_w          = 1'b0;
    din_w          = '0;
    busy           = 1'b0;
    halted         = 1'b0;

    case (state_reg)
      S_IDLE, S_HALTED: begin
        halted = (state_reg == S_HALTED);
        if (start) begin
          pc_next        = '0;
          prog_addr_next = '0;
          retired_next   = '0;
          err_next       = 1'b0;
          state_next     = S_FETCH;
        end
      end

      S_FETCH: begin
        // ROM is sampling pc now; pre-address the word after it so the
        // immediate (or don't-care word) is on prog_data during EXEC
        busy           = 1'b1;
        prog_addr_next = pc_reg + AW'(1);
        state_next     = S_ISSUE;
      end

      S_ISSUE: begin
        busy = 1'b1;
        if (opcode == OP_HALT) begin
          state_next = S_HALTED;
        end else if (opcode == OP_MVI && pc_is_last) begin
          // Immediate would lie past the program end: refuse to issue
          err_next   = 1'b1;
          state_next = S_HALTED;
        end else begin
          run_w      = 1'b1;
          din_w      = bus.prog_data;
          op_q_next  = opcode;
          wd_next    = '0;
          state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        busy    = 1'b1;
        run_w   = 1'b1;
        din_w   = bus.prog_data;
        wd_next = wd_reg + CW'(1);
        if (bus.done) begin
          if (retired_reg != 16'hFFFF) begin
            retired_next = retired_reg + 16'd1;
          end
          if (pc_step > (AW+1)'(PROG_LAST)) begin
            state_next = S_HALTED;
          end else begin
            pc_next        = pc_step[AW-1:0];
            prog_addr_next = pc_step[AW-1:0];
            state_next     = S_FETCH;
          end
        end else if (wd_reg == CW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th EXEC cycle without done
          err_next   = 1'b1;
          state_next = S_HALTED;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.run       = run_w;
  assign bus.din       = din_w;
  assign bus.prog_addr = prog_addr_reg;
  assign pc            = pc_reg;
  assign retired       = retired_reg;
  assign err           = err_reg;

endmodule
